// File: rtl/synapse_accumulator.sv
// synapse_accumulator
//   Event-driven synaptic current accumulator for a small neuron group.
//   A spike tag from an external FIFO selects a row of the weight matrix.
//   That row is added, with saturation, into every neuron's next-timestep
//   current. A timestep-end swap commits the next currents to the readable
//   bank and leaks the next bank by an arithmetic right shift.
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   asynchronous, active-high
//   fifo_empty in   spike FIFO empty (fired_tag valid when low)
//   fired_tag  in   TAGBITS, tag at the FIFO head
//   req_deq    out  pop strobe, high for the whole FETCH cycle
//   swap       in   one-cycle timestep-end pulse
//   w_en/w_src/w_dst/w_data  in   weight write mem[w_src][w_dst]
//   w_ready    out  weight write accepted this cycle (IDLE only)
//   rd_en/rd_tag             in   committed-current read request
//   i_out      out  NUMWIDTH+1, registered read data, 1-cycle latency
//   busy       out  state != IDLE
//   state_out  out  2-bit state encoding
//   ovf        out  one-cycle pulse after an ACCUM in which any lane clamped
module synapse_accumulator #(
    parameter int NUMWIDTH    = 16,
    parameter int TAGBITS     = 2,
    parameter int DECAY_SHIFT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fifo_empty,
    input  logic [TAGBITS-1:0]  fired_tag,
    output logic                req_deq,
    input  logic                swap,
    input  logic                w_en,
    input  logic [TAGBITS-1:0]  w_src,
    input  logic [TAGBITS-1:0]  w_dst,
    input  logic [NUMWIDTH:0]   w_data,
    output logic                w_ready,
    input  logic                rd_en,
    input  logic [TAGBITS-1:0]  rd_tag,
    output logic [NUMWIDTH:0]   i_out,
    output logic                busy,
    output logic [1:0]          state_out,
    output logic                ovf
);

    localparam int NUMNEURONS = 2 ** TAGBITS;
    localparam int WW         = NUMWIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        ACCUM = 2'b11,
        SWAP  = 2'b10
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic                   tag_load_s;
    logic [TAGBITS-1:0]     tag_r;
    logic                   swap_pending_r;
    logic                   ovf_r;
    logic [WW-1:0]          i_out_r;

    logic [WW-1:0]          mem_r    [NUMNEURONS][NUMNEURONS];
    logic [WW-1:0]          lane_r   [NUMNEURONS];
    logic signed [WW-1:0]   i_next_r [NUMNEURONS];
    logic [WW-1:0]          i_r      [NUMNEURONS];

    logic [WW:0]            acc_sum_s [NUMNEURONS];
    logic [WW-1:0]          acc_sat_s [NUMNEURONS];
    logic [NUMNEURONS-1:0]  clamp_s;

    // The extra top bit disagrees with the sign bit exactly when the
    // WW-bit signed result would have wrapped.
    function automatic logic sum_overflows(input logic [WW:0] sum);
        return sum[WW] ^ sum[WW-1];
    endfunction

    // Clamp a widened sum to the WW-bit signed range; the top bit
    // tells which rail was crossed.
    function automatic logic [WW-1:0] sat_word(input logic [WW:0] sum);
        logic [WW-1:0] res;
        if (!sum_overflows(sum)) begin
            res = sum[WW-1:0];
        end else if (sum[WW] == 1'b0) begin
            res = {1'b0, {NUMWIDTH{1'b1}}};
        end else begin
            res = {1'b1, {NUMWIDTH{1'b0}}};
        end
        return res;
    endfunction

    assign req_deq   = (state_r == FETCH);
    assign w_ready   = (state_r == IDLE);
    assign busy      = (state_r != IDLE);
    assign state_out = state_r;
    assign ovf       = ovf_r;
    assign i_out     = i_out_r;

    // Per-lane sign-extended add and saturation for the ACCUM update
    always_comb begin
        clamp_s = {NUMNEURONS{1'b0}};
        for (int k = 0; k < NUMNEURONS; k++) begin
            acc_sum_s[k] = {i_next_r[k][WW-1], i_next_r[k]} + {lane_r[k][WW-1], lane_r[k]};
            acc_sat_s[k] = sat_word(acc_sum_s[k]);
            clamp_s[k]   = sum_overflows(acc_sum_s[k]);
        end
    end

    // Next-state decode; spike work always wins over a pending swap
    always_comb begin
        state_next_s = state_r;
        tag_load_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next_s = FETCH;
                    tag_load_s   = 1'b1;
                end else if (swap || swap_pending_r) begin
                    state_next_s = SWAP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FETCH: begin
                state_next_s = ACCUM;
            end
            ACCUM: begin
                if (!fifo_empty) begin
                    state_next_s = FETCH;
                    tag_load_s   = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SWAP: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Control registers: state, latched tag, swap request, overflow pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            tag_r          <= {TAGBITS{1'b0}};
            swap_pending_r <= 1'b0;
            ovf_r          <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (tag_load_s) begin
                tag_r <= fired_tag;
            end else begin
                tag_r <= tag_r;
            end
            // A swap that cannot be served right now is remembered once;
            // entering SWAP consumes it.
            if (state_next_s == SWAP) begin
                swap_pending_r <= 1'b0;
            end else if (swap) begin
                swap_pending_r <= 1'b1;
            end else begin
                swap_pending_r <= swap_pending_r;
            end
            ovf_r <= (state_r == ACCUM) && (|clamp_s);
        end
    end

    // Weight matrix; writes only land while IDLE, so a write on the
    // IDLE->FETCH edge is already visible to the following FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUMNEURONS; s++) begin
                for (int d = 0; d < NUMNEURONS; d++) begin
                    mem_r[s][d] <= {WW{1'b0}};
                end
            end
        end else if (w_en && (state_r == IDLE)) begin
            mem_r[w_src][w_dst] <= w_data;
        end
    end

    // Lane, next-current and committed-current banks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUMNEURONS; k++) begin
                lane_r[k]   <= {WW{1'b0}};
                i_next_r[k] <= {WW{1'b0}};
                i_r[k]      <= {WW{1'b0}};
            end
        end else begin
            for (int k = 0; k < NUMNEURONS; k++) begin
                case (state_r)
                    FETCH: begin
                        lane_r[k] <= mem_r[tag_r][k];
                    end
                    ACCUM: begin
                        i_next_r[k] <= acc_sat_s[k];
                    end
                    SWAP: begin
                        i_r[k]      <= i_next_r[k];
                        i_next_r[k] <= i_next_r[k] >>> DECAY_SHIFT;
                    end
                    default: begin
                        lane_r[k] <= lane_r[k];
                    end
                endcase
            end
        end
    end

    // Read port; reads the pre-update bank, so a read during SWAP sees old data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_out_r <= {WW{1'b0}};
        end else if (rd_en) begin
            i_out_r <= i_r[rd_tag];
        end else begin
            i_out_r <= i_out_r;
        end
    end

endmodule
